// File: rtl/replay_pkg.sv
// Shared definitions for the sequence-numbered replay buffer.
//   ST_IDLE / ST_REPLAY : replay FSM state encoding
//   DLLP_ACK / DLLP_NAK : value of dllp_is_nak for each DLLP type
//   DEF_DATA_W / DEF_SEQ_W : default TLP and sequence-number widths
//   clog2()             : constant-foldable ceiling log2
package replay_pkg;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_SEQ_W  = 12;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REPLAY = 1'b1;

  localparam logic DLLP_ACK = 1'b0;
  localparam logic DLLP_NAK = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/replay_mem.sv
// Replay storage: 2**DEPTH_LOG2 x WIDTH register array.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data ({seq, tlp})
//   i_raddr : read address (combinational read)
//   o_rdata : read data
module replay_mem #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 140
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/replay_buffer_seq.sv
// Sequence-numbered TLP replay buffer. Holds CRC-protected TLPs until ACKed,
// purges on ACK/NAK, replays on NAK or replay-timer expiry, and pulses
// retrain_req when MAX_REPLAY replays happen without forward progress.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : TLP input from CRC stage
//   tx_valid/tx_ready/tx_data    : entry presented to link transmitter
//   tx_seq                       : sequence number of presented entry
//   dllp_valid/dllp_is_nak       : ACK/NAK strobe and type
//   dllp_seq                     : AckNak_Seq_Num
//   replay_active                : buffer is replaying
//   retrain_req                  : one-cycle replay-limit pulse
//   occupancy                    : entries held (sent or unsent, unacked)
//   next_seq                     : seq for next accepted TLP
module replay_buffer_seq
  import replay_pkg::*;
#(
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned DEPTH_LOG2     = 3,
  parameter int unsigned SEQ_W          = DEF_SEQ_W,
  parameter int unsigned TIMER_W        = 16,
  parameter int unsigned REPLAY_TIMEOUT = 1024,
  parameter int unsigned MAX_REPLAY     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_W-1:0]     tx_data,
  output logic [SEQ_W-1:0]      tx_seq,
  input  logic                  dllp_valid,
  input  logic                  dllp_is_nak,
  input  logic [SEQ_W-1:0]      dllp_seq,
  output logic                  replay_active,
  output logic                  retrain_req,
  output logic [DEPTH_LOG2:0]   occupancy,
  output logic [SEQ_W-1:0]      next_seq
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned RN_W  = clog2(MAX_REPLAY) + 1;

  logic [PTR_W-1:0]   r_head, r_txp, r_tail, r_replay_end;
  logic [SEQ_W-1:0]   r_next_seq;
  logic [TIMER_W-1:0] r_timer;
  logic [RN_W-1:0]    r_replay_num;
  logic [0:0]         r_state;
  logic               r_retrain;

  logic [PTR_W-1:0]        w_occ, w_sent, w_head_nxt, w_txp_adv;
  logic [SEQ_W-1:0]        w_head_seq, w_n;
  logic [SEQ_W+DATA_W-1:0] w_rd;
  logic [RN_W-1:0]         w_rn_base;
  logic w_replay, w_in_ready, w_wr, w_tx_valid, w_tx_hs;
  logic w_purge, w_nak_replay, w_timeout, w_start, w_rn_limit;
  logic w_txp_pass, w_replay_done;

  replay_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SEQ_W + DATA_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_tail[DEPTH_LOG2-1:0]),
    .i_wdata ({r_next_seq, in_data}),
    .i_raddr (r_txp[DEPTH_LOG2-1:0]),
    .o_rdata (w_rd)
  );

  assign w_occ      = r_tail - r_head;
  assign w_sent     = r_txp - r_head;
  assign w_replay   = (r_state == ST_REPLAY);
  assign w_in_ready = ~rst & (w_occ < PTR_W'(DEPTH)) & ~w_replay;
  assign w_wr       = in_valid & w_in_ready;
  assign w_tx_valid = (r_txp != r_tail);
  assign w_tx_hs    = w_tx_valid & tx_ready;
  assign w_txp_adv  = r_txp + PTR_W'(w_tx_hs);

  // Held sequence numbers are contiguous, so the head's seq follows from
  // next_seq and occupancy without a second memory read port.
  assign w_head_seq = r_next_seq - SEQ_W'(w_occ);
  assign w_n        = dllp_seq - w_head_seq + SEQ_W'(1);
  assign w_purge    = dllp_valid & (w_n != '0) & (w_n <= SEQ_W'(w_sent));
  assign w_head_nxt = w_purge ? (r_head + w_n[PTR_W-1:0]) : r_head;

  // NAK replays whatever is still outstanding after its purge; an entry
  // handshaken this same cycle counts as outstanding and is resent.
  assign w_nak_replay = dllp_valid & (dllp_is_nak == DLLP_NAK) &
                        (w_txp_adv != w_head_nxt);
  assign w_timeout    = (r_timer == TIMER_W'(REPLAY_TIMEOUT - 1)) &
                        (w_sent != '0) & ~w_purge;
  assign w_start      = ~w_replay & (w_nak_replay | w_timeout);

  assign w_rn_base  = w_purge ? '0 : r_replay_num;
  assign w_rn_limit = (w_rn_base == RN_W'(MAX_REPLAY - 1));

  // Offsets are taken relative to the old head so wrap is handled.
  assign w_txp_pass    = w_purge & ((w_head_nxt - r_head) > (w_txp_adv - r_head));
  assign w_replay_done = w_replay &
                         ((w_tx_hs & (w_txp_adv == r_replay_end)) |
                          (w_purge & (w_head_nxt == r_replay_end)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_txp        <= '0;
      r_tail       <= '0;
      r_replay_end <= '0;
      r_next_seq   <= '0;
      r_timer      <= '0;
      r_replay_num <= '0;
      r_state      <= ST_IDLE;
      r_retrain    <= 1'b0;
    end else begin
      r_head <= w_head_nxt;

      if (w_wr) begin
        r_tail     <= r_tail + 1'b1;
        r_next_seq <= r_next_seq + 1'b1;
      end

      if (w_start) begin
        r_replay_end <= w_txp_adv;
        r_txp        <= w_head_nxt;
        r_state      <= ST_REPLAY;
      end else begin
        r_txp <= w_txp_pass ? w_head_nxt : w_txp_adv;
        if (w_replay_done) r_state <= ST_IDLE;
      end

      if (w_replay | w_start | w_purge | (w_sent == '0)) r_timer <= '0;
      else                                               r_timer <= r_timer + 1'b1;

      if (w_start) r_replay_num <= w_rn_limit ? '0 : (w_rn_base + 1'b1);
      else         r_replay_num <= w_rn_base;

      r_retrain <= w_start & w_rn_limit;
    end
  end

  assign in_ready      = w_in_ready;
  assign tx_valid      = w_tx_valid;
  assign tx_seq        = w_rd[SEQ_W+DATA_W-1:DATA_W];
  assign tx_data       = w_rd[DATA_W-1:0];
  assign replay_active = w_replay;
  assign retrain_req   = r_retrain;
  assign occupancy     = w_occ;
  assign next_seq      = r_next_seq;

endmodule

// File: tb/tb_replay_buffer_seq.sv
// Testbench for replay_buffer_seq: directed stimulus, tx stream checked by
// a scoreboard monitor, status outputs checked against hand-computed values.
module tb_replay_buffer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic [11:0] tx_seq;
  logic        dllp_valid = 1'b0;
  logic        dllp_is_nak = 1'b0;
  logic [11:0] dllp_seq = '0;
  logic        replay_active;
  logic        retrain_req;
  logic [3:0]  occupancy;
  logic [11:0] next_seq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] sb[$];
  logic [43:0] mon_item;
  logic [31:0] exp_data [4096];
  logic [11:0] mdl_seq = '0;

  replay_buffer_seq #(
    .DATA_W         (32),
    .DEPTH_LOG2     (3),
    .SEQ_W          (12),
    .TIMER_W        (16),
    .REPLAY_TIMEOUT (16),
    .MAX_REPLAY     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_seq        (tx_seq),
    .dllp_valid    (dllp_valid),
    .dllp_is_nak   (dllp_is_nak),
    .dllp_seq      (dllp_seq),
    .replay_active (replay_active),
    .retrain_req   (retrain_req),
    .occupancy     (occupancy),
    .next_seq      (next_seq)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every tx handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got seq %0d data %h, required no transfer", tx_seq, tx_data);
      end else begin
        mon_item = sb.pop_front();
        if ({tx_seq, tx_data} !== mon_item) begin
          n_fail++;
          $display("FAIL sb_tx: got seq %0d data %h, required seq %0d data %h",
                   tx_seq, tx_data, mon_item[43:32], mon_item[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [11:0] s);
    sb.push_back({s, exp_data[s]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    dllp_valid = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    sb.delete();
    mdl_seq = '0;
    rst = 1'b0;
    step();
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_next_seq", next_seq, 0);
    chk("post_rst_replay", replay_active, 0);
    chk("post_rst_retrain", retrain_req, 0);
  endtask

  task automatic wr(input logic [31:0] d, input bit push);
    bit r;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int unsigned i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = in_ready;
      step();
      if (r) done = 1'b1;
    end
    in_valid = 1'b0;
    if (done) begin
      exp_data[mdl_seq] = d;
      if (push) push_tx(mdl_seq);
      mdl_seq = mdl_seq + 12'd1;
    end else begin
      chk("wr_accept", {31'd0, done}, 1);
    end
  endtask

  task automatic dllp(input logic nak, input logic [11:0] s);
    dllp_valid = 1'b1;
    dllp_is_nak = nak;
    dllp_seq = s;
    step();
    dllp_valid = 1'b0;
  endtask

  task automatic chk_drain(input string name);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    int unsigned k;
    bit got;

    // 1: three TLPs in order, ACK seq 1 purges two
    do_reset();
    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) wr(32'hA000_0000 + i, 1);
    repeat (2) step();
    chk("t1_occ3", occupancy, 3);
    chk("t1_tx_idle", tx_valid, 0);
    dllp(1'b0, 12'd1);
    chk("t1_ack1_occ", occupancy, 1);
    dllp(1'b0, 12'd2);
    chk("t1_ack2_occ", occupancy, 0);
    chk_drain("t1_drain");

    // 2: fill to 8 with link stalled; 9th offer held until space frees
    do_reset();
    tx_ready = 1'b0;
    for (int unsigned i = 0; i < 8; i++) wr(32'hB000_0000 + i, 1);
    chk("t2_full_occ", occupancy, 8);
    chk("t2_full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data = 32'hB000_0009;
    repeat (3) step();
    chk("t2_held_ready", in_ready, 0);
    tx_ready = 1'b1;
    repeat (10) step();
    chk("t2_full_tx_occ", occupancy, 8);
    chk("t2_full_tx_done", tx_valid, 0);
    dllp(1'b0, 12'd7);
    chk("t2_ack7_occ", occupancy, 0);
    exp_data[8] = 32'hB000_0009;
    push_tx(12'd8);
    got = 1'b0;
    for (int unsigned i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    mdl_seq = 12'd9;
    chk("t2_held_accepted", {31'd0, got}, 1);
    chk("t2_next_seq", next_seq, 9);
    repeat (2) step();
    dllp(1'b0, 12'd8);
    chk("t2_final_occ", occupancy, 0);
    chk_drain("t2_drain");

    // 3: send 0..4, NAK 1 -> replay 2,3,4
    do_reset();
    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) wr(32'hC100_0000 + i, 1);
    repeat (2) step();
    chk("t3_occ5", occupancy, 5);
    for (int unsigned i = 2; i < 5; i++) push_tx(12'(i));
    dllp(1'b1, 12'd1);
    chk("t3_replay_on", replay_active, 1);
    chk("t3_nak_occ", occupancy, 3);
    chk("t3_no_write", in_ready, 0);
    repeat (2) step();
    chk("t3_replay_mid", replay_active, 1);
    step();
    chk("t3_replay_off", replay_active, 0);
    dllp(1'b0, 12'd4);
    chk("t3_final_occ", occupancy, 0);
    chk_drain("t3_drain");

    // 4: timeout replays every 17 edges; 4th one pulses retrain_req
    do_reset();
    tx_ready = 1'b1;
    wr(32'hD000_0000, 1);
    for (int unsigned i = 0; i < 4; i++) push_tx(12'd0);
    for (int unsigned rep = 1; rep <= 4; rep++) begin
      k = 0;
      got = 1'b0;
      while (k < 40 && !got) begin
        step();
        k++;
        if (replay_active) got = 1'b1;
      end
      chk("t4_replay_edges", k, 17);
      chk("t4_retrain", retrain_req, (rep == 4) ? 1 : 0);
    end
    step();
    chk("t4_retrain_pulse", retrain_req, 0);
    repeat (2) step();
    dllp(1'b0, 12'd0);
    chk("t4_final_occ", occupancy, 0);
    chk_drain("t4_drain");

    // 5: 4100 TLPs with prompt ACKs, across the seq wrap
    do_reset();
    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 4100; i++) begin
      wr(32'hE000_0000 | i, 1);
      step();
      if (i == 4095) continue;
      if (i == 4096) begin
        dllp(1'b0, 12'd4095);
        chk("t5_ack4095_occ", occupancy, 1);
        dllp(1'b0, 12'd0);
        chk("t5_ack0_occ", occupancy, 0);
        chk("t5_wrap_next_seq", next_seq, 1);
      end else begin
        dllp(1'b0, 12'(i));
      end
    end
    chk("t5_final_occ", occupancy, 0);
    chk("t5_final_next_seq", next_seq, 4);
    chk_drain("t5_drain");

    // 6: stale/duplicate ACKs leave state and timer untouched
    do_reset();
    tx_ready = 1'b1;
    wr(32'hF000_0000, 1);
    wr(32'hF000_0001, 1);
    push_tx(12'd0);
    push_tx(12'd1);
    dllp(1'b0, 12'd4095);
    chk("t6_stale_occ", occupancy, 2);
    dllp(1'b0, 12'd5);
    chk("t6_ahead_occ", occupancy, 2);
    k = 2;
    got = 1'b0;
    while (k < 40 && !got) begin
      step();
      k++;
      if (replay_active) got = 1'b1;
    end
    chk("t6_timeout_edges", k, 16);
    repeat (3) step();
    dllp(1'b0, 12'd1);
    chk("t6_final_occ", occupancy, 0);
    chk_drain("t6_drain");

    // 7: reset mid-replay discards everything
    do_reset();
    tx_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) wr(32'h1700_0000 + i, 1);
    repeat (2) step();
    dllp(1'b1, 12'd0);
    chk("t7_replay_on", replay_active, 1);
    do_reset();
    chk("t7_rst_occ", occupancy, 0);
    wr(32'h1700_00AA, 1);
    step();
    dllp(1'b0, 12'd0);
    chk("t7_final_occ", occupancy, 0);
    chk_drain("t7_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
